// File: rtl/avalon_load_store_master.sv
// Avalon initiator for single CPU loads/stores.
// Formats lanes, extends load data, flags misalignment and timeouts.
module avalon_load_store_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam int unsigned CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_RDATA,
    S_RESP,
    S_ERR
  } state_e;

  state_e        state_q;
  logic          read_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [1:0]    lsb_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [CW-1:0] cnt_q;
  logic          resp_valid_q;
  logic          resp_error_q;
  logic [31:0]   resp_rdata_q;

  logic          misalign_d;
  logic [4:0]    sh_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   lane_d;
  logic [31:0]   rdata_d;
  logic          timeout_hit;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = addr_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

  assign sh_d   = {req_addr[1:0], 3'b000};
  assign lane_d = readdata >> {lsb_q, 3'b000};

  assign timeout_hit = (TIMEOUT != 0) &&
                       (cnt_q == CW'(TIMEOUT - 1));

  // Alignment rule per access size; size 11 is never legal.
  always_comb begin
    misalign_d = 1'b1;
    unique case (req_size)
      2'b00:   misalign_d = 1'b0;
      2'b01:   misalign_d = req_addr[0];
      2'b10:   misalign_d = |req_addr[1:0];
      default: misalign_d = 1'b1;
    endcase
  end

  // Byte lanes and lane-placed store data; lane 0 maps to byteenable[3].
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    unique case (req_size)
      2'b00: begin
        be_d    = 4'b1000 >> req_addr[1:0];
        wdata_d = {24'h0, req_wdata[7:0]} << sh_d;
      end
      2'b01: begin
        be_d    = 4'b1100 >> req_addr[1:0];
        wdata_d = {16'h0, req_wdata[15:0]} << sh_d;
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  // Load data extraction and sign/zero extension.
  always_comb begin
    rdata_d = lane_d;
    unique case (size_q)
      2'b00: rdata_d = signed_q ?
        {{24{lane_d[7]}}, lane_d[7:0]} :
        {24'h0, lane_d[7:0]};
      2'b01: rdata_d = signed_q ?
        {{16{lane_d[15]}}, lane_d[15:0]} :
        {16'h0, lane_d[15:0]};
      default: rdata_d = lane_d;
    endcase
  end

  // Request/bus/response state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      lsb_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            lsb_q    <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            if (misalign_d) begin
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else begin
              state_q <= S_BUS;
              addr_q  <= {req_addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              read_q  <= ~req_write;
              write_q <= req_write;
              cnt_q   <= '0;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (write_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_RDATA;
            end
          end else if (timeout_hit) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            state_q      <= S_ERR;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RDATA: begin
          resp_rdata_q <= rdata_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_load_store_master.sv
// Directed bench for avalon_load_store_master.
// Scoreboard of expected responses against a one-wait-state memory.
module tb_avalon_load_store_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;
  logic        waitrequest;

  always #5 clk = ~clk;

  avalon_load_store_master #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .address    (address),
    .read       (read),
    .write      (write),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  logic [31:0] mem [0:15] = '{1: 32'hCAFEF00D, default: 32'h0};
  logic        ws_done;
  logic        stuck = 1'b0;

  logic        prev_act = 1'b0;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic        cap_wr;
  logic        rw_both = 1'b0;
  logic        unstable = 1'b0;
  int          bus_cycles = 0;
  int          read_cycles = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  assign waitrequest = stuck | ((read | write) & ~ws_done);

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: one wait state per access; lane i is byteenable[3-i].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_done <= 1'b0;
    end else if (read | write) begin
      if (waitrequest) begin
        ws_done <= 1'b1;
      end else begin
        ws_done <= 1'b0;
        if (read) begin
          readdata <= mem[address[5:2]];
        end else begin
          for (int i = 0; i < 4; i++)
            if (byteenable[3-i])
              mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end else begin
      ws_done <= 1'b0;
    end
  end

  // Response monitor and bus-protocol observation.
  always @(negedge clk) begin
    if (read && write) rw_both = 1'b1;
    if (read || write) bus_cycles++;
    if (read) read_cycles++;
    if ((read || write) && !prev_act) begin
      cap_addr = address;
      cap_be   = byteenable;
      cap_wd   = writedata;
      cap_wr   = write;
    end else if (read || write) begin
      if (address !== cap_addr || byteenable !== cap_be ||
          writedata !== cap_wd || write !== cap_wr)
        unstable = 1'b1;
    end
    prev_act = read || write;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", {31'h0, resp_error}, {31'h0, e.err});
        check("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] wd, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    if (push) sb.push_back('{exp_rd, exp_err, exp_lat, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_wait", sb.size(), 32'd0);
  endtask

  initial begin
    int bc0;
    int rc0;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_wdata  = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {28'h0, read, write, resp_valid, resp_error}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_be", {28'h0, byteenable}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    rst_n = 1'b1;

    issue(1, 32'hBFC00000, 2'b10, 0, 32'h8899AABB, 1, 32'h0, 0, 3);
    wait_resp();
    check("sw_be", {28'h0, cap_be}, 32'hF);
    check("sw_wd", cap_wd, 32'h8899AABB);
    check("sw_wr", {31'h0, cap_wr}, 32'd1);

    issue(0, 32'hBFC00001, 2'b00, 1, 32'h0, 1, 32'hFFFFFFAA, 0, 4);
    wait_resp();
    check("lb_be", {28'h0, cap_be}, 32'h4);
    check("lb_addr", cap_addr, 32'hBFC00000);

    issue(0, 32'hBFC00002, 2'b01, 0, 32'h0, 1, 32'h00008899, 0, 4);
    wait_resp();
    check("lhu_be", {28'h0, cap_be}, 32'h3);

    issue(1, 32'hBFC00003, 2'b00, 0, 32'h0000005A, 1, 32'h0, 0, 3);
    wait_resp();
    check("sb_be", {28'h0, cap_be}, 32'h1);
    check("sb_wd", cap_wd, 32'h5A000000);
    check("sb_wr", {31'h0, cap_wr}, 32'd1);

    issue(0, 32'hBFC00000, 2'b10, 0, 32'h0, 1, 32'h5A99AABB, 0, 4);
    issue(0, 32'hBFC00000, 2'b01, 1, 32'h0, 1, 32'hFFFFAABB, 0, 4);
    issue(0, 32'hBFC00002, 2'b00, 0, 32'h0, 1, 32'h00000099, 0, 4);
    issue(1, 32'hBFC00002, 2'b01, 0, 32'hFFFF1234, 1, 32'h0, 0, 3);
    wait_resp();
    check("sh_be", {28'h0, cap_be}, 32'h3);
    check("sh_wd", cap_wd, 32'h12340000);
    issue(0, 32'hBFC00000, 2'b10, 0, 32'h0, 1, 32'h1234AABB, 0, 4);
    issue(1, 32'hBFC00000, 2'b00, 0, 32'hFFFFFF80, 1, 32'h0, 0, 3);
    wait_resp();
    check("sb0_be", {28'h0, cap_be}, 32'h8);
    check("sb0_wd", cap_wd, 32'h00000080);
    issue(0, 32'hBFC00000, 2'b00, 1, 32'h0, 1, 32'hFFFFFF80, 0, 4);
    wait_resp();

    bc0 = bus_cycles;
    issue(0, 32'hBFC00002, 2'b10, 0, 32'h0, 1, 32'h0, 1, 1);
    issue(0, 32'hBFC00001, 2'b01, 1, 32'h0, 1, 32'h0, 1, 1);
    issue(1, 32'hBFC00000, 2'b11, 0, 32'h1, 1, 32'h0, 1, 1);
    wait_resp();
    check("misaligned_nobus", bus_cycles - bc0, 32'd0);

    stuck = 1'b1;
    rc0 = read_cycles;
    issue(0, 32'hBFC00000, 2'b10, 0, 32'h0, 1, 32'h0, 1, 9);
    wait_resp();
    check("timeout_read_cycles", read_cycles - rc0, 32'd8);
    stuck = 1'b0;
    issue(0, 32'hBFC00004, 2'b10, 0, 32'h0, 1, 32'hCAFEF00D, 0, 4);
    wait_resp();

    stuck = 1'b1;
    issue(0, 32'hBFC00000, 2'b10, 0, 32'h0, 0, 32'h0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_pre_read", {31'h0, read}, 32'd1);
    rst_n = 1'b0;
    #1 check("rst_read_drop", {31'h0, read}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    check("rst_ready_after", {31'h0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    issue(0, 32'hBFC00000, 2'b10, 0, 32'h0, 1, 32'h1234AA80, 0, 4);
    wait_resp();

    check("rw_exclusive", {31'h0, rw_both}, 32'd0);
    check("bus_stable", {31'h0, unstable}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
